// File: rtl/ctrl_microondas_param.sv
// Parametrised microwave oven controller: time/power editing, presets, countdown with
// duty-cycled magnetron, door lamp and a timed alarm phase after completion.
module ctrl_microondas_param #(
  parameter int TICK_DIV   = 100000000,
  parameter int PWR_LEVELS = 3,
  parameter int N_PRESETS  = 3,
  parameter logic [N_PRESETS*7-1:0] PRESET_MIN = {7'd1, 7'd3, 7'd99},
  parameter logic [N_PRESETS*6-1:0] PRESET_SEC = {6'd15, 6'd30, 6'd30},
  parameter logic [N_PRESETS*8-1:0] PRESET_PWR = {8'd3, 8'd2, 8'd1},
  parameter int MAX_MIN    = 99,
  parameter int QUICK_SEC  = 30,
  parameter int ALARM_SEC  = 3,
  localparam int PW = $clog2(PWR_LEVELS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pause,
  input  logic                 door,
  input  logic                 plus,
  input  logic                 minus,
  input  logic                 pwr_sel,
  input  logic [1:0]           step_sel,
  input  logic [N_PRESETS-1:0] preset,
  output logic [6:0]           min,
  output logic [5:0]           sec,
  output logic [PW-1:0]        pwr_level,
  output logic [1:0]           state,
  output logic                 magnetron,
  output logic                 lamp,
  output logic                 alarm,
  output logic                 done
);

  // state | meaning
  // IDLE  | editing time/power, presets, waiting for start
  // COOK  | counting down, magnetron duty-cycled by window counter
  // PAUSE | counters frozen, waiting for resume or stop
  // DONE  | alarm phase for ALARM_SEC ticks
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COOK  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = (PWR_LEVELS > 1) ? $clog2(PWR_LEVELS) : 1;
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [6:0]    MAX_M   = 7'(MAX_MIN);
  localparam logic [PW-1:0] PWR_MAX = PW'(PWR_LEVELS);

  logic [TW-1:0] tick_cnt;
  logic [WW-1:0] win_cnt;
  logic [AW-1:0] alarm_cnt;

  logic start_q, stop_q, pause_q, plus_q, minus_q;
  logic [N_PRESETS-1:0] preset_q;

  logic start_e, stop_e, pause_e, plus_e, minus_e;
  logic [N_PRESETS-1:0] preset_e;

  assign start_e  = start & ~start_q;
  assign stop_e   = stop & ~stop_q;
  assign pause_e  = pause & ~pause_q;
  assign plus_e   = plus & ~plus_q;
  assign minus_e  = minus & ~minus_q;
  assign preset_e = preset & ~preset_q;

  logic          tick_wrap;
  logic [WW-1:0] win_nxt;
  logic [6:0]    dec_min;
  logic [5:0]    dec_sec;
  logic          dec_zero;

  assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
  assign win_nxt   = (win_cnt == WW'(PWR_LEVELS - 1)) ? '0 : win_cnt + 1'b1;
  assign dec_min   = (sec == 6'd0) ? min - 7'd1 : min;
  assign dec_sec   = (sec == 6'd0) ? 6'd59 : sec - 6'd1;
  assign dec_zero  = (min == 7'd0) && (sec == 6'd1);

  logic [6:0]    p_min;
  logic [5:0]    p_sec;
  logic [PW-1:0] p_pwr;

  // Scan downwards so the lowest-index asserted preset wins.
  always_comb begin
    p_min = '0;
    p_sec = '0;
    p_pwr = PWR_MAX;
    for (int i = N_PRESETS - 1; i >= 0; i--) begin
      if (preset[i]) begin
        p_min = PRESET_MIN[i*7 +: 7];
        p_sec = PRESET_SEC[i*6 +: 6];
        p_pwr = PW'(PRESET_PWR[i*8 +: 8]);
      end
    end
  end

  logic [6:0] ed_min;
  logic [5:0] ed_sec;

  always_comb begin
    ed_min = min;
    ed_sec = sec;
    if (plus_e & ~minus_e) begin
      case (step_sel)
        2'b00: begin
          if (sec != 6'd59) ed_sec = sec + 6'd1;
          else if (min < MAX_M) begin
            ed_sec = 6'd0;
            ed_min = min + 7'd1;
          end
        end
        2'b01: begin
          if (sec < 6'd50) ed_sec = sec + 6'd10;
          else if (min < MAX_M) begin
            ed_sec = sec - 6'd50;
            ed_min = min + 7'd1;
          end else ed_sec = 6'd59;
        end
        2'b10: begin
          if (({1'b0, min} + 8'd1) > {1'b0, MAX_M}) begin
            ed_min = MAX_M;
            ed_sec = 6'd59;
          end else ed_min = min + 7'd1;
        end
        default: begin
          if (({1'b0, min} + 8'd10) > {1'b0, MAX_M}) begin
            ed_min = MAX_M;
            ed_sec = 6'd59;
          end else ed_min = min + 7'd10;
        end
      endcase
    end else if (minus_e & ~plus_e) begin
      case (step_sel)
        2'b00: begin
          if (sec != 6'd0) ed_sec = sec - 6'd1;
          else if (min != 7'd0) begin
            ed_sec = 6'd59;
            ed_min = min - 7'd1;
          end
        end
        2'b01: begin
          if (sec >= 6'd10) ed_sec = sec - 6'd10;
          else if (min != 7'd0) begin
            ed_sec = sec + 6'd50;
            ed_min = min - 7'd1;
          end else ed_sec = 6'd0;
        end
        2'b10:   ed_min = (min != 7'd0) ? min - 7'd1 : 7'd0;
        default: ed_min = (min >= 7'd10) ? min - 7'd10 : 7'd0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      min       <= '0;
      sec       <= '0;
      pwr_level <= PWR_MAX;
      tick_cnt  <= '0;
      win_cnt   <= '0;
      alarm_cnt <= '0;
      done      <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      pause_q   <= 1'b0;
      plus_q    <= 1'b0;
      minus_q   <= 1'b0;
      preset_q  <= '0;
    end else begin
      start_q  <= start;
      stop_q   <= stop;
      pause_q  <= pause;
      plus_q   <= plus;
      minus_q  <= minus;
      preset_q <= preset;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_e & ~door) begin
            if (min == 7'd0 && sec == 6'd0) sec <= 6'(QUICK_SEC);
            tick_cnt <= '0;
            win_cnt  <= '0;
            state    <= S_COOK;
          end else if (|preset_e) begin
            min       <= p_min;
            sec       <= p_sec;
            pwr_level <= p_pwr;
          end else if (plus_e ^ minus_e) begin
            if (pwr_sel) begin
              if (plus_e && pwr_level < PWR_MAX) pwr_level <= pwr_level + 1'b1;
              if (minus_e && pwr_level > PW'(1)) pwr_level <= pwr_level - 1'b1;
            end else begin
              min <= ed_min;
              sec <= ed_sec;
            end
          end
        end
        S_COOK: begin
          if (stop_e) begin
            state <= S_IDLE;
            min   <= '0;
            sec   <= '0;
          end else if (door | pause_e) begin
            state <= S_PAUSE;
          end else if (tick_wrap) begin
            tick_cnt <= '0;
            min      <= dec_min;
            sec      <= dec_sec;
            win_cnt  <= win_nxt;
            if (dec_zero) begin
              state     <= S_DONE;
              done      <= 1'b1;
              alarm_cnt <= '0;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_PAUSE: begin
          if (stop_e) begin
            state <= S_IDLE;
            min   <= '0;
            sec   <= '0;
          end else if ((start_e | pause_e) & ~door) begin
            state <= S_COOK;
          end
        end
        default: begin
          if (stop_e | start_e | door) begin
            state <= S_IDLE;
          end else if (tick_wrap) begin
            tick_cnt <= '0;
            if (alarm_cnt == AW'(ALARM_SEC - 1)) state <= S_IDLE;
            else alarm_cnt <= alarm_cnt + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Door term stays combinational so opening the door kills the magnetron immediately.
  assign magnetron = (state == S_COOK) && (32'(win_cnt) < 32'(pwr_level)) && !door;
  assign lamp      = door | (state == S_COOK);
  assign alarm     = (state == S_DONE);

endmodule

// File: tb/tb_ctrl_microondas_param.sv
// Bench for ctrl_microondas_param: directed scenarios plus a randomized run, all
// checked against a total-seconds reference model of the oven.
module tb_ctrl_microondas_param;

  localparam int TD    = 4;
  localparam int PL    = 3;
  localparam int MAXT  = 99 * 60 + 59;
  localparam int QUICK = 30;
  localparam int ALRM  = 3;

  logic       clock, reset, start, stop, pause, door, plus, minus, pwr_sel;
  logic [1:0] step_sel;
  logic [2:0] preset;
  logic [6:0] min;
  logic [5:0] sec;
  logic [1:0] pwr_level;
  logic [1:0] state;
  logic       magnetron, lamp, alarm, done;

  ctrl_microondas_param #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .door(door), .plus(plus), .minus(minus), .pwr_sel(pwr_sel), .step_sel(step_sel),
    .preset(preset), .min(min), .sec(sec), .pwr_level(pwr_level), .state(state),
    .magnetron(magnetron), .lamp(lamp), .alarm(alarm), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_fail = 0;

  // reference model: time as total seconds, state 0 idle / 1 cook / 2 pause / 3 done
  int m_state, m_t, m_pwr, m_tick, m_win, m_al;
  bit m_done;
  bit p_start, p_stop, p_pause, p_plus, p_minus;
  logic [2:0] p_preset;
  int pm[3] = '{99, 3, 1};
  int ps[3] = '{30, 30, 15};
  int pp[3] = '{1, 2, 3};

  wire [20:0] act_vec = {min, sec, pwr_level, state, magnetron, lamp, alarm, done};

  function automatic logic [20:0] exp_vec();
    bit mag;
    mag = (m_state == 1) && (m_win < m_pwr) && !door;
    return {7'(m_t / 60), 6'(m_t % 60), 2'(m_pwr), 2'(m_state), mag,
            door || (m_state == 1), m_state == 3, m_done};
  endfunction

  task automatic model_step();
    bit es, est, ep, epl, emi, anyp;
    int idx, mm, ss, k;
    es = start && !p_start;  est = stop && !p_stop;  ep = pause && !p_pause;
    epl = plus && !p_plus;   emi = minus && !p_minus;
    anyp = |(preset & ~p_preset);
    p_start = start; p_stop = stop; p_pause = pause; p_plus = plus; p_minus = minus;
    p_preset = preset;
    if (reset) begin
      m_state = 0; m_t = 0; m_pwr = PL; m_tick = 0; m_win = 0; m_al = 0; m_done = 0;
      p_start = 0; p_stop = 0; p_pause = 0; p_plus = 0; p_minus = 0; p_preset = 0;
      return;
    end
    m_done = 0;
    case (m_state)
      0: begin
        if (es && !door) begin
          if (m_t == 0) m_t = QUICK;
          m_tick = 0; m_win = 0; m_state = 1;
        end else if (anyp) begin
          idx = 0;
          for (int i = 2; i >= 0; i--) if (preset[i]) idx = i;
          m_t = pm[idx] * 60 + ps[idx];
          m_pwr = pp[idx];
        end else if (epl != emi) begin
          if (pwr_sel) begin
            if (epl && m_pwr < PL) m_pwr++;
            if (emi && m_pwr > 1) m_pwr--;
          end else begin
            mm = m_t / 60; ss = m_t % 60;
            k = step_sel[0] ? 10 : 1;
            if (!step_sel[1]) m_t = epl ? ((m_t + k > MAXT) ? MAXT : m_t + k)
                                        : ((m_t - k < 0) ? 0 : m_t - k);
            else if (epl) m_t = (mm + k > 99) ? MAXT : m_t + 60 * k;
            else m_t = (mm >= k) ? m_t - 60 * k : ss;
          end
        end
      end
      1: begin
        if (est) begin m_state = 0; m_t = 0; end
        else if (door || ep) m_state = 2;
        else if (m_tick == TD - 1) begin
          m_tick = 0; m_t--; m_win = (m_win + 1) % PL;
          if (m_t == 0) begin m_state = 3; m_done = 1; m_al = 0; end
        end else m_tick++;
      end
      2: begin
        if (est) begin m_state = 0; m_t = 0; end
        else if ((es || ep) && !door) m_state = 1;
      end
      default: begin
        if (est || es || door) m_state = 0;
        else if (m_tick == TD - 1) begin
          m_tick = 0; m_al++;
          if (m_al == ALRM) m_state = 0;
        end else m_tick++;
      end
    endcase
  endtask

  task automatic clk_step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic press_edit(input bit up, input logic [1:0] ss, input int n);
    pwr_sel = 0; step_sel = ss;
    repeat (n) begin
      plus = up; minus = !up; clk_step();
      plus = 0; minus = 0; clk_step();
    end
  endtask

  task automatic press_pwr(input bit up, input int n);
    pwr_sel = 1;
    repeat (n) begin
      plus = up; minus = !up; clk_step();
      plus = 0; minus = 0; clk_step();
    end
    pwr_sel = 0;
  endtask

  task automatic press_stop();
    stop = 1; clk_step(); stop = 0; clk_step();
  endtask

  task automatic set_time(input int m, input int s);
    press_edit(0, 2'b11, 10);
    press_edit(0, 2'b01, 6);
    press_edit(1, 2'b11, m / 10);
    press_edit(1, 2'b10, m % 10);
    press_edit(1, 2'b01, s / 10);
    press_edit(1, 2'b00, s % 10);
  endtask

  task automatic test_reset();
    reset = 1; clk_step(); clk_step();
    n_vec++;
    if (act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_vec got=%h want=%h", act_vec, exp_vec());
    end
    n_vec++;
    if ({min, sec, pwr_level, state, done, alarm} !== {7'd0, 6'd0, 2'd3, 2'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_const got=%0d:%0d pwr=%0d st=%0d want=0:0 pwr=3 st=0",
                         min, sec, pwr_level, state);
    end
    reset = 0; clk_step();
  endtask

  task automatic test_time_edit();
    set_time(0, 58);
    press_edit(1, 2'b00, 1);
    n_vec++;
    if (min !== 7'd0 || sec !== 6'd59) begin
      n_fail++; $display("FAIL sec_plus1 got=%0d:%0d want=0:59", min, sec);
    end
    press_edit(1, 2'b00, 1);
    n_vec++;
    if (min !== 7'd1 || sec !== 6'd0) begin
      n_fail++; $display("FAIL sec_wrap got=%0d:%0d want=1:0", min, sec);
    end
    set_time(0, 55);
    press_edit(1, 2'b01, 1);
    n_vec++;
    if (min !== 7'd1 || sec !== 6'd5) begin
      n_fail++; $display("FAIL sec_plus10 got=%0d:%0d want=1:5", min, sec);
    end
    set_time(95, 0);
    press_edit(1, 2'b11, 1);
    n_vec++;
    if (min !== 7'd99 || sec !== 6'd59) begin
      n_fail++; $display("FAIL min_sat got=%0d:%0d want=99:59", min, sec);
    end
    set_time(0, 5);
    press_edit(0, 2'b01, 1);
    n_vec++;
    if (act_vec !== exp_vec() || min !== 7'd0 || sec !== 6'd0) begin
      n_fail++; $display("FAIL sec_minus10_floor got=%h want=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_cook_done();
    set_time(0, 2);
    start = 1; clk_step(); start = 0;
    n_vec++;
    if (state !== 2'd1) begin
      n_fail++; $display("FAIL start_edge state got=%0d want=1", state);
    end
    for (int i = 1; i <= 8; i++) begin
      clk_step();
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL cook_cyc%0d got=%h want=%h", i, act_vec, exp_vec());
      end
    end
    n_vec++;
    if (state !== 2'd3 || done !== 1'b1 || sec !== 6'd0 || alarm !== 1'b1) begin
      n_fail++; $display("FAIL cook_done got st=%0d done=%b sec=%0d al=%b want 3 1 0 1",
                         state, done, sec, alarm);
    end
    for (int i = 1; i <= 12; i++) begin
      clk_step();
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL alarm_cyc%0d got=%h want=%h", i, act_vec, exp_vec());
      end
      if (i == 1 || i == 11) begin
        n_vec++;
        if (done !== 1'b0 || state !== 2'd3) begin
          n_fail++; $display("FAIL alarm_hold%0d got st=%0d done=%b want 3 0", i, state, done);
        end
      end
    end
    n_vec++;
    if (state !== 2'd0 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL alarm_end got st=%0d al=%b want 0 0", state, alarm);
    end
  endtask

  task automatic test_door_pause();
    set_time(0, 5);
    start = 1; clk_step(); start = 0;
    clk_step(); clk_step();
    door = 1; #1;
    n_vec++;
    if (magnetron !== 1'b0 || lamp !== 1'b1) begin
      n_fail++; $display("FAIL door_comb got mag=%b lamp=%b want 0 1", magnetron, lamp);
    end
    clk_step();
    n_vec++;
    if (state !== 2'd2 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL door_pause got=%h want=%h", act_vec, exp_vec());
    end
    door = 0; clk_step();
    n_vec++;
    if (state !== 2'd2) begin
      n_fail++; $display("FAIL door_close got st=%0d want=2", state);
    end
    pause = 1; clk_step(); pause = 0;
    n_vec++;
    if (state !== 2'd1 || sec !== 6'd5) begin
      n_fail++; $display("FAIL resume got st=%0d sec=%0d want 1 5", state, sec);
    end
    clk_step();
    n_vec++;
    if (sec !== 6'd5) begin
      n_fail++; $display("FAIL resume_partial1 got sec=%0d want=5", sec);
    end
    clk_step();
    n_vec++;
    if (sec !== 6'd4 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL resume_partial2 got=%h want=%h", act_vec, exp_vec());
    end
    press_stop();
  endtask

  task automatic test_pwm();
    press_pwr(0, 2);
    set_time(0, 6);
    start = 1; clk_step(); start = 0;
    for (int k = 0; k < 24; k++) begin
      n_vec++;
      if (magnetron !== (((k / 4) % 3) == 0) || act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL pwm1_k%0d got mag=%b vec=%h want=%h", k, magnetron, act_vec, exp_vec());
      end
      clk_step();
    end
    press_stop();
    press_pwr(1, 2);
    set_time(0, 3);
    start = 1; clk_step(); start = 0;
    for (int k = 0; k < 12; k++) begin
      n_vec++;
      if (magnetron !== 1'b1) begin
        n_fail++; $display("FAIL pwm3_k%0d got mag=%b want=1", k, magnetron);
      end
      clk_step();
    end
    press_stop();
  endtask

  task automatic test_preset();
    preset = 3'b010; clk_step();
    n_vec++;
    if (min !== 7'd3 || sec !== 6'd30 || pwr_level !== 2'd2) begin
      n_fail++; $display("FAIL preset1 got=%0d:%0d p%0d want=3:30 p2", min, sec, pwr_level);
    end
    preset = 3'b011; clk_step();
    n_vec++;
    if (min !== 7'd99 || sec !== 6'd30 || pwr_level !== 2'd1 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL preset0 got=%0d:%0d p%0d want=99:30 p1", min, sec, pwr_level);
    end
    preset = 3'b000; clk_step();
    start = 1; clk_step(); start = 0; clk_step();
    preset = 3'b100; clk_step();
    n_vec++;
    if (state !== 2'd1 || pwr_level !== 2'd1 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL preset_cook got=%h want=%h", act_vec, exp_vec());
    end
    preset = 3'b000;
    press_stop();
    start = 1; clk_step(); start = 0;
    n_vec++;
    if (state !== 2'd1 || min !== 7'd0 || sec !== 6'd30) begin
      n_fail++; $display("FAIL quick_start got st=%0d %0d:%0d want 1 0:30", state, min, sec);
    end
    press_stop();
  endtask

  task automatic test_stop_reset();
    set_time(1, 12);
    start = 1; clk_step(); start = 0;
    repeat (8) clk_step();
    n_vec++;
    if (min !== 7'd1 || sec !== 6'd10) begin
      n_fail++; $display("FAIL cook_1_10 got=%0d:%0d want=1:10", min, sec);
    end
    stop = 1; clk_step(); stop = 0;
    n_vec++;
    if (state !== 2'd0 || min !== 7'd0 || sec !== 6'd0 || pwr_level !== 2'(m_pwr)) begin
      n_fail++; $display("FAIL stop_cook got st=%0d %0d:%0d p%0d want 0 0:0 p%0d",
                         state, min, sec, pwr_level, m_pwr);
    end
    clk_step();
    start = 1; clk_step(); start = 0;
    repeat (3) clk_step();
    reset = 1; clk_step(); reset = 0;
    n_vec++;
    if (act_vec !== {7'd0, 6'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_cook got=%h want=%h", act_vec,
                         {7'd0, 6'd0, 2'd3, 2'd0, 4'b0});
    end
    set_time(0, 20);
    plus = 1; minus = 1; clk_step(); plus = 0; minus = 0; clk_step();
    n_vec++;
    if (min !== 7'd0 || sec !== 6'd20 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL plus_minus got=%0d:%0d want=0:20", min, sec);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 5) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      pause    = ($urandom_range(0, 9) == 0);
      plus     = ($urandom_range(0, 4) == 0);
      minus    = ($urandom_range(0, 3) == 0);
      pwr_sel  = ($urandom_range(0, 2) == 0);
      step_sel = 2'($urandom_range(0, 3));
      preset   = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 24) == 0) door = !door;
      clk_step();
      n_vec++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rand_%0d got=%h want=%h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; pause = 0; door = 0; plus = 0; minus = 0;
    pwr_sel = 0; step_sel = 2'b00; preset = 3'b000;
    test_reset();
    test_time_edit();
    test_cook_done();
    test_door_pause();
    test_pwm();
    test_preset();
    test_stop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
